// File: rtl/alu_pkg.sv
// Shared constants and state type for the pipelined ALU control stage.
package alu_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned FN_W   = 6;
  localparam int unsigned AOP_W  = 2;
  localparam int unsigned CNT_W  = 8;

  localparam logic [CODE_W-1:0] OP_AND  = 4'b0000;
  localparam logic [CODE_W-1:0] OP_OR   = 4'b0001;
  localparam logic [CODE_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [CODE_W-1:0] OP_XOR  = 4'b0011;
  localparam logic [CODE_W-1:0] OP_SLL  = 4'b0100;
  localparam logic [CODE_W-1:0] OP_SRL  = 4'b0101;
  localparam logic [CODE_W-1:0] OP_SUB  = 4'b0110;
  localparam logic [CODE_W-1:0] OP_SLT  = 4'b0111;
  localparam logic [CODE_W-1:0] OP_MULT = 4'b1000;
  localparam logic [CODE_W-1:0] OP_DIV  = 4'b1001;
  localparam logic [CODE_W-1:0] OP_NOR  = 4'b1100;
  localparam logic [CODE_W-1:0] OP_NOP  = 4'b1111;

  localparam logic [FN_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [FN_W-1:0] FN_AND  = 6'b100100;
  localparam logic [FN_W-1:0] FN_OR   = 6'b100101;
  localparam logic [FN_W-1:0] FN_XOR  = 6'b100110;
  localparam logic [FN_W-1:0] FN_NOR  = 6'b100111;
  localparam logic [FN_W-1:0] FN_SLT  = 6'b101010;
  localparam logic [FN_W-1:0] FN_SLL  = 6'b000000;
  localparam logic [FN_W-1:0] FN_SRL  = 6'b000010;
  localparam logic [FN_W-1:0] FN_MULT = 6'b011000;
  localparam logic [FN_W-1:0] FN_DIV  = 6'b011010;

  localparam logic [AOP_W-1:0] AOP_LS  = 2'b00;
  localparam logic [AOP_W-1:0] AOP_BR  = 2'b01;
  localparam logic [AOP_W-1:0] AOP_RT  = 2'b10;
  localparam logic [AOP_W-1:0] AOP_ORI = 2'b11;

  typedef enum logic {IDLE, MD} state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational ALUOp/funct decode into an operation code, illegal flag and multi-cycle flag.
module alu_decode
  import alu_pkg::*;
#(
  parameter int unsigned FUNC_W  = 6,
  parameter int unsigned ALUOP_W = 2,
  parameter int unsigned OP_W    = 4
) (
  input  logic [FUNC_W-1:0]  func,
  input  logic [ALUOP_W-1:0] alu_op,
  output logic [OP_W-1:0]    op_next,
  output logic               illegal_next,
  output logic               is_md
);

  logic [FN_W-1:0]   fn;
  logic [AOP_W-1:0]  aop;
  logic              hi_nz;
  logic [CODE_W-1:0] code;

  always_comb begin
    fn           = func[FN_W-1:0];
    aop          = alu_op[AOP_W-1:0];
    hi_nz        = ((func >> FN_W) != '0) || ((alu_op >> AOP_W) != '0);
    code         = OP_NOP;
    illegal_next = 1'b0;
    is_md        = 1'b0;
    case (aop)
      AOP_LS:  code = OP_ADD;
      AOP_BR:  code = OP_SUB;
      AOP_ORI: code = OP_OR;
      default: begin
        case (fn)
          FN_ADD:  code = OP_ADD;
          FN_SUB:  code = OP_SUB;
          FN_AND:  code = OP_AND;
          FN_OR:   code = OP_OR;
          FN_XOR:  code = OP_XOR;
          FN_NOR:  code = OP_NOR;
          FN_SLT:  code = OP_SLT;
          FN_SLL:  code = OP_SLL;
          FN_SRL:  code = OP_SRL;
          FN_MULT: begin code = OP_MULT; is_md = 1'b1; end
          FN_DIV:  begin code = OP_DIV;  is_md = 1'b1; end
          default: illegal_next = 1'b1;
        endcase
      end
    endcase
    // Non-zero bits above the decoded field make the whole instruction illegal.
    if (hi_nz) begin
      code         = OP_NOP;
      illegal_next = 1'b1;
      is_md        = 1'b0;
    end
    op_next = OP_W'(code);
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control stage with stall/flush handling and a MULT/DIV stall sequencer.
module alu_ctrl_pipe
  import alu_pkg::*;
#(
  parameter int unsigned FUNC_W    = 6,
  parameter int unsigned ALUOP_W   = 2,
  parameter int unsigned OP_W      = 4,
  parameter int unsigned MD_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [FUNC_W-1:0]  func,
  input  logic [ALUOP_W-1:0] alu_op,
  output logic [OP_W-1:0]    operation,
  output logic               out_valid,
  output logic               illegal,
  output logic               md_start,
  output logic               stall_req
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_d;
  logic             valid_d, illegal_d, md_start_d, stall_req_d;

  logic [OP_W-1:0]  dec_op;
  logic             dec_illegal, dec_md;

  alu_decode #(
    .FUNC_W (FUNC_W),
    .ALUOP_W(ALUOP_W),
    .OP_W   (OP_W)
  ) u_decode (
    .func        (func),
    .alu_op      (alu_op),
    .op_next     (dec_op),
    .illegal_next(dec_illegal),
    .is_md       (dec_md)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      operation <= OP_W'(OP_NOP);
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      md_start  <= 1'b0;
      stall_req <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      operation <= op_d;
      out_valid <= valid_d;
      illegal   <= illegal_d;
      md_start  <= md_start_d;
      stall_req <= stall_req_d;
    end
  end

  // Next-state and next-output logic; everything holds unless changed below.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = operation;
    valid_d     = out_valid;
    illegal_d   = illegal;
    md_start_d  = 1'b0;
    stall_req_d = stall_req;
    case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d   = 1'b0;
          illegal_d = 1'b0;
        end else if (stall) begin
          valid_d = out_valid;
        end else if (in_valid) begin
          op_d      = dec_op;
          illegal_d = dec_illegal;
          valid_d   = 1'b1;
          if (dec_md) begin
            md_start_d  = 1'b1;
            stall_req_d = 1'b1;
            cnt_d       = CNT_W'(MD_CYCLES - 1);
            state_d     = MD;
          end
        end else begin
          valid_d = 1'b0;
        end
      end
      MD: begin
        if (flush) begin
          state_d     = IDLE;
          cnt_d       = '0;
          valid_d     = 1'b0;
          illegal_d   = 1'b0;
          stall_req_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d     = IDLE;
          valid_d     = 1'b0;
          stall_req_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        stall_req_d = 1'b0;
      end
    endcase
  end

endmodule
